// File: rtl/pc_sequencer_if.sv
// Handshake bundle between the multi-cycle sequencer and the PC/IR/regfile/memory datapath.
// The sequencer takes the master modport; the datapath side takes the slave modport.
interface pc_sequencer_if #(
  parameter int OPW = 6,
  parameter int CW  = 16
);
  logic           start;
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;
  logic           pc_en;
  logic           pc_sel;
  logic           ir_load;
  logic           mem_req;
  logic           mem_we;
  logic           reg_write;
  logic           busy;
  logic           halted;
  logic           illegal;
  logic [CW-1:0]  instr_count;

  modport master (
    input  start, opcode, zero, mem_ready,
    output pc_en, pc_sel, ir_load, mem_req, mem_we, reg_write,
           busy, halted, illegal, instr_count
  );

  modport slave (
    output start, opcode, zero, mem_ready,
    input  pc_en, pc_sel, ir_load, mem_req, mem_we, reg_write,
           busy, halted, illegal, instr_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and drives PC enable/select, IR load, memory requests and register write-back.
module pc_sequencer #(
  parameter int W   = 6,
  parameter int OPW = 6,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          clr,
  pc_sequencer_if.master bus
);
  // The sequencer never holds a PC; W only documents the PC width it controls.
  if (W < 1 || W > 31) begin : g_bad_w
    $error("pc_sequencer: PC width W out of range");
  end

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(6'b111111);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] instr_count_q, instr_count_d;
  logic          illegal_q, illegal_d;

  logic pc_en, pc_sel, ir_load, mem_req, mem_we, reg_write;
  logic set_illegal;

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    ir_load     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    reg_write   = 1'b0;
    set_illegal = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (bus.opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (bus.opcode == OP_J) begin
          pc_en   = 1'b1;
          pc_sel  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_WB;
          OP_LW, OP_SW: state_d = S_MEM;
          OP_BEQ: begin
            pc_en   = 1'b1;
            pc_sel  = bus.zero;
            state_d = S_FETCH;
          end
          default: begin
            // Unknown opcodes retire as a NOP and flag the sticky error.
            pc_en       = 1'b1;
            set_illegal = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (bus.opcode == OP_SW);
        if (bus.mem_ready) begin
          if (bus.opcode == OP_SW) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_en     = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    illegal_d     = illegal_q | set_illegal;
    instr_count_d = instr_count_q;
    if (pc_en && (instr_count_q != {CW{1'b1}})) begin
      instr_count_d = instr_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= S_IDLE;
      instr_count_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
      illegal_q     <= illegal_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.pc_sel      = pc_sel;
  assign bus.ir_load     = ir_load;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.reg_write   = reg_write;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted      = (state_q == S_HALT);
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = instr_count_q;
endmodule
